// File: rtl/seq_pkg.sv
// Shared types, widths and defaults for the program sequencer.
`timescale 1ns/1ps
package seq_pkg;

    localparam int PROG_IDX_W    = 32'd2;
    localparam int DEF_NUM_PROGS = 32'd3;
    localparam int DEF_PC_W      = 32'd10;
    localparam int DEF_CYC_W     = 32'd16;
    localparam int DEF_TIMEOUT   = 32'hFFFF;
    localparam int DEF_START_LEN = 32'd1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        WAIT_LOW = 3'd2,
        RUN      = 3'd3,
        NEXT     = 3'd4,
        FINISH   = 3'd5
    } state_t;

    // States in which the current program's run time is being accumulated.
    function automatic logic is_counting(input state_t st);
        return (st == WAIT_LOW) || (st == RUN);
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// Saturating up-counter with synchronous clear and enable.
`timescale 1ns/1ps
module cycle_counter #(
    parameter int CYC_W = 32'd16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CYC_W-1:0] count
);

    localparam logic [CYC_W-1:0] ALL_ONES = {CYC_W{1'b1}};

    logic [CYC_W-1:0] count_d;
    logic [CYC_W-1:0] count_q;

    // Next count: clear beats enable, and the count sticks at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CYC_W{1'b0}};
        end else if (en && (count_q != ALL_ONES)) begin
            count_d = count_q + CYC_W'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CYC_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/program_sequencer.sv
// Runs NUM_PROGS programs back-to-back on the core: start pulse, Ack handshake,
// per-program cycle timing and a watchdog that aborts a hung program.
`timescale 1ns/1ps
module program_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_PROGS = DEF_NUM_PROGS,
    parameter int PC_W      = DEF_PC_W,
    parameter int CYC_W     = DEF_CYC_W,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int START_LEN = DEF_START_LEN
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Go,
    input  logic [NUM_PROGS*PC_W-1:0] ProgBase,
    input  logic                      CoreAck,
    output logic                      CoreStart,
    output logic [PC_W-1:0]           StartAddr,
    output logic [PROG_IDX_W-1:0]     ProgIdx,
    output logic [CYC_W-1:0]          CycleCount,
    output logic [CYC_W-1:0]          LastCycles,
    output logic                      LastValid,
    output logic                      Busy,
    output logic                      AllDone,
    output logic                      TimedOut
);

    localparam int                    SL_W         = (START_LEN > 32'd1) ? $clog2(START_LEN) : 32'd1;
    localparam logic [CYC_W-1:0]      TIMEOUT_V    = CYC_W'(TIMEOUT);
    localparam logic [CYC_W-1:0]      TIMEOUT_LAST = CYC_W'(TIMEOUT - 32'd1);
    localparam logic [PROG_IDX_W-1:0] LAST_IDX     = PROG_IDX_W'(NUM_PROGS - 32'd1);
    localparam logic [SL_W-1:0]       START_RELOAD = SL_W'(START_LEN - 32'd1);

    state_t                  state_d;
    state_t                  state_q;
    logic [PROG_IDX_W-1:0]   prog_idx_d;
    logic [PROG_IDX_W-1:0]   prog_idx_q;
    logic [PROG_IDX_W-1:0]   launch_idx_s;
    logic [PC_W-1:0]         start_addr_d;
    logic [PC_W-1:0]         start_addr_q;
    logic [PC_W-1:0]         base_sel_s;
    logic [SL_W-1:0]         start_cnt_d;
    logic [SL_W-1:0]         start_cnt_q;
    logic [CYC_W-1:0]        last_cycles_d;
    logic [CYC_W-1:0]        last_cycles_q;
    logic [CYC_W-1:0]        cycle_count_s;
    logic                    timed_out_d;
    logic                    timed_out_q;
    logic                    core_start_d;
    logic                    core_start_q;
    logic                    last_valid_d;
    logic                    last_valid_q;
    logic                    busy_d;
    logic                    busy_q;
    logic                    all_done_d;
    logic                    all_done_q;
    logic                    launch_s;
    logic                    count_en_s;
    logic                    watchdog_s;

    // Index the next launch uses: step forward from NEXT, otherwise restart at 0.
    always_comb begin
        if (state_q == NEXT) begin
            launch_idx_s = prog_idx_q + PROG_IDX_W'(1'b1);
        end else begin
            launch_idx_s = {PROG_IDX_W{1'b0}};
        end
    end

    // Start-PC table mux; exactly one slot matches the launch index.
    always_comb begin
        base_sel_s = {PC_W{1'b0}};
        for (int i = 0; i < NUM_PROGS; i++) begin
            base_sel_s = base_sel_s |
                ((PROG_IDX_W'(i) == launch_idx_s) ? ProgBase[i*PC_W +: PC_W] : {PC_W{1'b0}});
        end
    end

    assign count_en_s = is_counting(state_q);
    assign watchdog_s = (cycle_count_s == TIMEOUT_LAST);

    // Next-state logic; a fresh Ack only counts once Ack has been seen low.
    always_comb begin
        state_d       = state_q;
        prog_idx_d    = prog_idx_q;
        start_addr_d  = start_addr_q;
        start_cnt_d   = start_cnt_q;
        last_cycles_d = last_cycles_q;
        timed_out_d   = timed_out_q;
        launch_s      = 1'b0;
        case (state_q)
            IDLE, FINISH: begin
                if (Go) begin
                    launch_s     = 1'b1;
                    timed_out_d  = 1'b0;
                    state_d      = LAUNCH;
                    prog_idx_d   = launch_idx_s;
                    start_addr_d = base_sel_s;
                    start_cnt_d  = START_RELOAD;
                end else begin
                    state_d = state_q;
                end
            end
            LAUNCH: begin
                if (start_cnt_q == {SL_W{1'b0}}) begin
                    state_d = WAIT_LOW;
                end else begin
                    start_cnt_d = start_cnt_q - SL_W'(1'b1);
                end
            end
            WAIT_LOW: begin
                if (watchdog_s) begin
                    state_d       = FINISH;
                    timed_out_d   = 1'b1;
                    last_cycles_d = TIMEOUT_V;
                end else if (!CoreAck) begin
                    state_d = RUN;
                end else begin
                    state_d = WAIT_LOW;
                end
            end
            RUN: begin
                if (CoreAck) begin
                    state_d       = NEXT;
                    last_cycles_d = cycle_count_s;
                end else if (watchdog_s) begin
                    state_d       = FINISH;
                    timed_out_d   = 1'b1;
                    last_cycles_d = TIMEOUT_V;
                end else begin
                    state_d = RUN;
                end
            end
            NEXT: begin
                if (prog_idx_q == LAST_IDX) begin
                    state_d = FINISH;
                end else begin
                    launch_s     = 1'b1;
                    state_d      = LAUNCH;
                    prog_idx_d   = launch_idx_s;
                    start_addr_d = base_sel_s;
                    start_cnt_d  = START_RELOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status flags decode the state being entered, so every port comes from a flop.
    always_comb begin
        core_start_d = (state_d == LAUNCH);
        last_valid_d = (state_d == NEXT);
        all_done_d   = (state_d == FINISH);
        busy_d       = (state_d == LAUNCH) || (state_d == WAIT_LOW) ||
                       (state_d == RUN)    || (state_d == NEXT);
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            prog_idx_q    <= {PROG_IDX_W{1'b0}};
            start_addr_q  <= {PC_W{1'b0}};
            start_cnt_q   <= {SL_W{1'b0}};
            last_cycles_q <= {CYC_W{1'b0}};
            timed_out_q   <= 1'b0;
            core_start_q  <= 1'b0;
            last_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            all_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            prog_idx_q    <= prog_idx_d;
            start_addr_q  <= start_addr_d;
            start_cnt_q   <= start_cnt_d;
            last_cycles_q <= last_cycles_d;
            timed_out_q   <= timed_out_d;
            core_start_q  <= core_start_d;
            last_valid_q  <= last_valid_d;
            busy_q        <= busy_d;
            all_done_q    <= all_done_d;
        end
    end

    cycle_counter #(
        .CYC_W (CYC_W)
    ) u_cycle_counter (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (launch_s),
        .en    (count_en_s),
        .count (cycle_count_s)
    );

    assign CoreStart  = core_start_q;
    assign StartAddr  = start_addr_q;
    assign ProgIdx    = prog_idx_q;
    assign CycleCount = cycle_count_s;
    assign LastCycles = last_cycles_q;
    assign LastValid  = last_valid_q;
    assign Busy       = busy_q;
    assign AllDone    = all_done_q;
    assign TimedOut   = timed_out_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Randomized bench for program_sequencer against a behavioural run/ack model.
`timescale 1ns/1ps
module tb_program_sequencer;

    localparam int NP  = 3;
    localparam int PCW = 10;
    localparam int CW  = 8;
    localparam int TMO = 150;
    localparam int SL  = 2;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            Go;
    logic [NP*PCW-1:0] ProgBase;
    logic            CoreAck;
    logic            CoreStart;
    logic [PCW-1:0]  StartAddr;
    logic [1:0]      ProgIdx;
    logic [CW-1:0]   CycleCount;
    logic [CW-1:0]   LastCycles;
    logic            LastValid;
    logic            Busy;
    logic            AllDone;
    logic            TimedOut;

    program_sequencer #(
        .NUM_PROGS(NP), .PC_W(PCW), .CYC_W(CW), .TIMEOUT(TMO), .START_LEN(SL)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Go(Go), .ProgBase(ProgBase), .CoreAck(CoreAck),
        .CoreStart(CoreStart), .StartAddr(StartAddr), .ProgIdx(ProgIdx),
        .CycleCount(CycleCount), .LastCycles(LastCycles), .LastValid(LastValid),
        .Busy(Busy), .AllDone(AllDone), .TimedOut(TimedOut)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of one run.
    int m_idx, m_addr, m_cnt, m_last, m_launch_left;
    bit m_waiting, m_seen_low, m_completed, m_done, m_tout;
    int base_tbl[NP];
    int low_at[NP];   // count from which the core lets Ack fall
    int ack_at[NP];   // count at which the core raises Ack (-1: never)
    bit chk_en = 1'b0;
    int dut_lv_log[$];
    int dut_addr_log[$];
    int dut_launches = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_idx = 0; m_addr = 0; m_cnt = 0; m_last = 0; m_launch_left = 0;
        m_waiting = 0; m_seen_low = 0; m_completed = 0; m_done = 0; m_tout = 0;
    endfunction

    function automatic void model_launch();
        m_addr = base_tbl[m_idx];
        m_cnt = 0;
        m_launch_left = SL;
        m_done = 0;
    endfunction

    // One clock edge of the specified behaviour, given the sampled inputs.
    function automatic void model_step(input bit go, input bit ack);
        if (m_completed) begin
            m_completed = 0;
            if (m_idx == NP - 1) m_done = 1;
            else begin
                m_idx++;
                model_launch();
            end
        end else if (m_launch_left > 0) begin
            m_launch_left--;
            if (m_launch_left == 0) begin
                m_waiting = 1;
                m_seen_low = 0;
            end
        end else if (m_waiting) begin
            if (m_seen_low && ack) begin
                m_last = m_cnt;
                m_completed = 1;
                m_waiting = 0;
            end else if (m_cnt == TMO - 1) begin
                m_tout = 1;
                m_last = TMO;
                m_waiting = 0;
                m_done = 1;
            end else if (!ack) begin
                m_seen_low = 1;
            end
            if (m_cnt != (1 << CW) - 1) m_cnt++;
        end else if (go) begin
            m_idx = 0;
            m_tout = 0;
            model_launch();
        end
    endfunction

    // Core stand-in: Ack is a level that only moves while a program is running.
    function automatic bit agent_ack(input bit cur);
        if (!m_waiting) return cur;
        if (m_cnt < low_at[m_idx]) return cur;
        if (ack_at[m_idx] >= 0 && m_cnt >= ack_at[m_idx]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic pack_base();
        for (int i = 0; i < NP; i++) ProgBase[i*PCW +: PCW] = base_tbl[i][PCW-1:0];
    endtask

    task automatic step();
        CoreAck = agent_ack(CoreAck);
        @(posedge Clk);
        if (Reset) model_step(Go, CoreAck);
        @(negedge Clk);
        Go = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input bit noise);
        int n;
        n = 0;
        while (!m_done && n < budget) begin
            if (noise && $urandom_range(0, 15) == 0) Go = 1'b1;
            if (noise && $urandom_range(0, 49) == 0) begin
                base_tbl[$urandom_range(0, NP - 1)] = int'($urandom_range(0, (1 << PCW) - 1));
                pack_base();
            end
            step();
            n++;
        end
        if (!m_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_budget: got %0d cycles without finish, required finish within %0d", n, budget);
        end
    endtask

    task automatic start_run(input int l0, input int a0, input int l1, input int a1,
                             input int l2, input int a2);
        low_at[0] = l0; ack_at[0] = a0;
        low_at[1] = l1; ack_at[1] = a1;
        low_at[2] = l2; ack_at[2] = a2;
        dut_lv_log.delete();
        dut_addr_log.delete();
        dut_launches = 0;
        Go = 1'b1;
        step();
    endtask

    task automatic check_log(input string name, input int n_exp, input int e0, input int e1, input int e2);
        int e[3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        chk({name, "_pulses"}, dut_lv_log.size(), n_exp);
        for (int i = 0; i < n_exp && i < dut_lv_log.size(); i++)
            chk($sformatf("%s_last%0d", name, i), dut_lv_log[i], e[i]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_CoreStart"}, CoreStart, 0);
        chk({tag, "_StartAddr"}, StartAddr, 0);
        chk({tag, "_ProgIdx"}, ProgIdx, 0);
        chk({tag, "_CycleCount"}, CycleCount, 0);
        chk({tag, "_LastCycles"}, LastCycles, 0);
        chk({tag, "_LastValid"}, LastValid, 0);
        chk({tag, "_Busy"}, Busy, 0);
        chk({tag, "_AllDone"}, AllDone, 0);
        chk({tag, "_TimedOut"}, TimedOut, 0);
    endtask

    // Per-cycle compare of every output against the model.
    initial begin
        bit prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge Clk);
            if (chk_en) begin
                chk("CoreStart", CoreStart, m_launch_left > 0);
                chk("StartAddr", StartAddr, m_addr);
                chk("ProgIdx", ProgIdx, m_idx);
                chk("CycleCount", CycleCount, m_cnt);
                chk("LastCycles", LastCycles, m_last);
                chk("LastValid", LastValid, m_completed);
                chk("Busy", Busy, (m_launch_left > 0) || m_waiting || m_completed);
                chk("AllDone", AllDone, m_done);
                chk("TimedOut", TimedOut, m_tout);
                if (LastValid) dut_lv_log.push_back(int'(LastCycles));
                if (CoreStart && !prev_start) begin
                    dut_launches++;
                    dut_addr_log.push_back(int'(StartAddr));
                end
            end
            prev_start = CoreStart;
        end
    end

    initial begin
        int n;
        Reset = 1'b0; Go = 1'b0; CoreAck = 1'b0;
        base_tbl[0] = 'h012; base_tbl[1] = 'h155; base_tbl[2] = 'h3A0;
        pack_base();
        model_reset();
        repeat (3) @(negedge Clk);
        check_zero("reset");
        Reset = 1'b1;
        chk_en = 1'b1;

        // Plain three-program run.
        start_run(0, 40, 0, 75, 0, 120);
        run_until_done(2000, 1'b0);
        check_log("basic", 3, 40, 75, 120);
        chk("basic_addr0", dut_addr_log.size() > 0 ? dut_addr_log[0] : -1, 'h012);
        chk("basic_addr1", dut_addr_log.size() > 1 ? dut_addr_log[1] : -1, 'h155);
        chk("basic_addr2", dut_addr_log.size() > 2 ? dut_addr_log[2] : -1, 'h3A0);
        chk("basic_AllDone", AllDone, 1);
        chk("basic_TimedOut", TimedOut, 0);
        chk("basic_model_last", m_last, 120);

        // Ack left high into program 1 must not complete it early.
        start_run(0, 30, 10, 50, 0, 20);
        run_until_done(2000, 1'b0);
        check_log("stale", 3, 30, 50, 20);

        // Program 1 never acks: watchdog aborts, program 2 never launched.
        start_run(0, 25, 0, -1, 0, 30);
        run_until_done(2000, 1'b0);
        check_log("tmo", 1, 25, 0, 0);
        chk("tmo_TimedOut", TimedOut, 1);
        chk("tmo_LastCycles", LastCycles, TMO);
        chk("tmo_model_last", m_last, 150);
        chk("tmo_ProgIdx", ProgIdx, 1);
        chk("tmo_launches", dut_launches, 2);
        chk("tmo_AllDone", AllDone, 1);

        // Go in FINISH restarts; Ack on the exact watchdog cycle wins; Go noise ignored.
        start_run(0, TMO - 1, 0, 60, 0, 45);
        chk("restart_TimedOut", TimedOut, 0);
        chk("restart_ProgIdx", ProgIdx, 0);
        chk("restart_CoreStart", CoreStart, 1);
        run_until_done(2000, 1'b1);
        check_log("edge", 3, 149, 60, 45);
        chk("edge_TimedOut", TimedOut, 0);

        // Reset mid-RUN of program 1.
        start_run(0, 20, 0, 100, 0, 20);
        n = 0;
        while (!(m_idx == 1 && m_waiting && m_seen_low && m_cnt == 30) && n < 2000) begin
            step();
            n++;
        end
        chk("rst_reach_prog1", n < 2000, 1);
        #2 Reset = 1'b0;
        model_reset();
        #1 check_zero("rst_run");
        step(); step();
        Reset = 1'b1;

        // Reset while CoreStart is high drops it immediately.
        start_run(0, 20, 0, 20, 0, 20);
        chk("rst_launch_pre", CoreStart, 1);
        #2 Reset = 1'b0;
        model_reset();
        #1 chk("rst_launch_CoreStart", CoreStart, 0);
        step();
        Reset = 1'b1;

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NP; i++) base_tbl[i] = int'($urandom_range(0, (1 << PCW) - 1));
            pack_base();
            for (int i = 0; i < NP; i++) begin
                low_at[i] = int'($urandom_range(0, 5));
                case ($urandom_range(0, 7))
                    0: ack_at[i] = -1;
                    1: ack_at[i] = TMO - 1;
                    default: ack_at[i] = low_at[i] + 1 + int'($urandom_range(0, 60));
                endcase
            end
            start_run(low_at[0], ack_at[0], low_at[1], ack_at[1], low_at[2], ack_at[2]);
            run_until_done(2000, 1'b1);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
